// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants, stage indices and divider-handshake state encoding
// for the pipeline hazard/flush controller.
package pipe_hazard_ctrl_pkg;

  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC00380;
  localparam logic [31:0] DEFAULT_ERET_CODE  = 32'h0000000E;

  localparam int STG_IF     = 0;
  localparam int STG_ID     = 1;
  localparam int STG_EX     = 2;
  localparam int STG_MEM    = 3;
  localparam int STG_WB     = 4;
  localparam int NUM_STAGES = 5;

  typedef logic [NUM_STAGES-1:0] stage_vec_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Mask with every stage from IF up to and including 'last' set.
  function automatic stage_vec_t stages_upto(input int last);
    stage_vec_t m;
    m = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (i <= last) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_div_handshake_fsm.sv
// Divider start/wait handshake: registered start pulse, abort on exception,
// and the IF..EX freeze while a division is in flight.
module pipe_hazard_ctrl_div_handshake_fsm
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic div_op,
  input  logic except,
  input  logic div_ready,
  input  logic mem_stall,
  output logic div_start,
  output logic div_abort,
  output logic div_stall
);

  div_state_e state, state_next;
  logic       start_next;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DIV_IDLE;
      div_start <= 1'b0;
    end else begin
      state     <= state_next;
      div_start <= start_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    start_next = 1'b0;
    div_abort  = 1'b0;
    div_stall  = 1'b0;
    case (state)
      DIV_IDLE: begin
        // Hold the divide in EX during the launch cycle as well.
        if (div_op && !except) begin
          state_next = DIV_BUSY;
          start_next = 1'b1;
          div_stall  = 1'b1;
        end
      end
      DIV_BUSY: begin
        if (except) begin
          state_next = DIV_IDLE;
          div_abort  = 1'b1;
        // div_ready is still the previous result while the start pulse is out.
        end else if (div_ready && !div_start) begin
          state_next = mem_stall ? DIV_DONE : DIV_IDLE;
        end else begin
          div_stall = 1'b1;
        end
      end
      DIV_DONE: begin
        if (except) begin
          state_next = DIV_IDLE;
          div_abort  = 1'b1;
        end else if (!mem_stall) begin
          state_next = DIV_IDLE;
        end
      end
      default: state_next = DIV_IDLE;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and flush controller: load-use detection, divider handshake,
// exception/ERET redirect with fetch-stall hold, and a stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int          LOAD_USE_DIST = 1,
  parameter logic [31:0] EXC_VECTOR    = DEFAULT_EXC_VECTOR,
  parameter logic [31:0] ERET_CODE     = DEFAULT_ERET_CODE,
  parameter int          PERF_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              ex_rmem,
  input  logic [4:0]        ex_wa,
  input  logic              mem_rmem,
  input  logic [4:0]        mem_wa,
  input  logic              ex_div_op,
  input  logic              div_ready,
  output logic              div_start,
  output logic              div_abort,
  input  logic              stallreq_from_if,
  input  logic              stallreq_from_mem,
  input  logic [31:0]       mem_excepttype,
  input  logic [31:0]       mem_cp0_epc,
  output logic [4:0]        stall,
  output logic [4:0]        flush,
  output logic              redirect_valid,
  output logic [31:0]       mem_newpc,
  output logic [PERF_W-1:0] stall_cycles
);

  logic        except;
  logic [31:0] target;
  logic        lu_ex, lu_mem, lu;
  logic        div_stall;
  logic        ex_frozen;
  logic        pending;
  logic [31:0] held_target;

  assign except = (mem_excepttype != 32'd0);
  assign target = (mem_excepttype == ERET_CODE) ? mem_cp0_epc : EXC_VECTOR;

  assign lu_ex  = ex_rmem && (ex_wa != 5'd0) && ((ex_wa == id_rs) || (ex_wa == id_rt));
  assign lu_mem = mem_rmem && (mem_wa != 5'd0) && ((mem_wa == id_rs) || (mem_wa == id_rt));
  assign lu     = lu_ex || ((LOAD_USE_DIST >= 2) && lu_mem);

  pipe_hazard_ctrl_div_handshake_fsm u_div_fsm (
    .clk       (clk),
    .rst       (rst),
    .div_op    (ex_div_op),
    .except    (except),
    .div_ready (div_ready),
    .mem_stall (stallreq_from_mem),
    .div_start (div_start),
    .div_abort (div_abort),
    .div_stall (div_stall)
  );

  // A redirect that lands while fetch is stalled is replayed until fetch accepts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= 1'b0;
      held_target <= 32'd0;
    end else if (except) begin
      pending <= stallreq_from_if;
      if (stallreq_from_if) held_target <= target;
    end else if (!stallreq_from_if) begin
      pending <= 1'b0;
    end
  end

  assign ex_frozen = stallreq_from_mem || div_stall;

  always_comb begin
    stall          = '0;
    flush          = '0;
    redirect_valid = 1'b0;
    mem_newpc      = 32'd0;
    if (except) begin
      flush          = '1;
      redirect_valid = 1'b1;
      mem_newpc      = target;
    end else begin
      if (stallreq_from_mem) begin
        stall         |= stages_upto(STG_MEM);
        flush[STG_WB]  = 1'b1;
      end
      if (div_stall) stall |= stages_upto(STG_EX);
      if (lu) begin
        stall |= stages_upto(STG_ID);
        // A frozen EX keeps its instruction; the bubble is only needed when EX moves.
        if (!ex_frozen) flush[STG_EX] = 1'b1;
      end
      if (stallreq_from_if) stall |= stages_upto(STG_ID);
      if (pending) begin
        redirect_valid = 1'b1;
        mem_newpc      = held_target;
        flush[STG_IF]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall[STG_IF] && (stall_cycles != {PERF_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (deep load-use, 4-bit counter).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_wa, mem_wa;
  logic        ex_rmem, mem_rmem, ex_div_op, div_ready;
  logic        div_start, div_abort;
  logic        stallreq_from_if, stallreq_from_mem;
  logic [31:0] mem_excepttype, mem_cp0_epc;
  logic [4:0]  stall, flush;
  logic        redirect_valid;
  logic [31:0] mem_newpc;
  logic [3:0]  stall_cycles;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .LOAD_USE_DIST (2),
    .PERF_W        (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .ex_rmem           (ex_rmem),
    .ex_wa             (ex_wa),
    .mem_rmem          (mem_rmem),
    .mem_wa            (mem_wa),
    .ex_div_op         (ex_div_op),
    .div_ready         (div_ready),
    .div_start         (div_start),
    .div_abort         (div_abort),
    .stallreq_from_if  (stallreq_from_if),
    .stallreq_from_mem (stallreq_from_mem),
    .mem_excepttype    (mem_excepttype),
    .mem_cp0_epc       (mem_cp0_epc),
    .stall             (stall),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .mem_newpc         (mem_newpc),
    .stall_cycles      (stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_wa = 5'd0; mem_wa = 5'd0;
    ex_rmem = 1'b0; mem_rmem = 1'b0; ex_div_op = 1'b0; div_ready = 1'b0;
    stallreq_from_if = 1'b0; stallreq_from_mem = 1'b0;
    mem_excepttype = 32'd0; mem_cp0_epc = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    #2;
    check("rst_stall", stall, 5'b00000);
    check("rst_flush", flush, 5'b00000);
    check("rst_redirect", redirect_valid, 1'b0);
    check("rst_newpc", mem_newpc, 32'd0);
    check("rst_div_start", div_start, 1'b0);
    check("rst_cnt", stall_cycles, 4'd0);
    tick();
    rst = 1'b0;

    // Load-use on EX via rt
    ex_rmem = 1'b1; ex_wa = 5'd5; id_rt = 5'd5;
    #1;
    check("lu_ex_rt_stall", stall, 5'b00011);
    check("lu_ex_rt_flush", flush, 5'b00100);
    tick();
    ex_wa = 5'd0; id_rt = 5'd0;
    #1;
    check("lu_r0_stall", stall, 5'b00000);
    check("lu_r0_flush", flush, 5'b00000);
    // Load-use on EX via rs
    ex_wa = 5'd7; id_rs = 5'd7;
    #1;
    check("lu_ex_rs_stall", stall, 5'b00011);
    check("lu_ex_rs_flush", flush, 5'b00100);
    tick();
    check("cnt_after_lu", stall_cycles, 4'd2);
    // Load-use under mem stall: EX frozen, no EX bubble
    stallreq_from_mem = 1'b1;
    #1;
    check("lu_memstall_stall", stall, 5'b01111);
    check("lu_memstall_flush", flush, 5'b10000);
    tick();
    // Load-use against MEM-stage load (distance 2)
    stallreq_from_mem = 1'b0; ex_rmem = 1'b0; ex_wa = 5'd0; id_rs = 5'd0;
    mem_rmem = 1'b1; mem_wa = 5'd9; id_rt = 5'd9;
    #1;
    check("lu_mem_stall", stall, 5'b00011);
    check("lu_mem_flush", flush, 5'b00100);
    tick();
    mem_wa = 5'd0;
    #1;
    check("lu_mem_r0_stall", stall, 5'b00000);
    check("cnt_before_div", stall_cycles, 4'd4);
    clear_inputs();

    // Divide with memory stall at completion
    ex_div_op = 1'b1;
    #1;
    check("div_launch_stall", stall, 5'b00111);
    check("div_launch_start", div_start, 1'b0);
    tick();
    check("div_start_pulse", div_start, 1'b1);
    check("div_busy0_stall", stall, 5'b00111);
    tick();
    check("div_start_low", div_start, 1'b0);
    check("div_busy1_stall", stall, 5'b00111);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("div_busy_stall", stall, 5'b00111);
      check("div_busy_start", div_start, 1'b0);
    end
    div_ready = 1'b1; stallreq_from_mem = 1'b1;
    #1;
    check("div_ready_memstall_stall", stall, 5'b01111);
    check("div_ready_memstall_flush", flush, 5'b10000);
    tick();
    for (int i = 0; i < 2; i++) begin
      check("div_done_stall", stall, 5'b01111);
      tick();
      check("div_done_no_restart", div_start, 1'b0);
    end
    stallreq_from_mem = 1'b0;
    #1;
    check("div_done_release", stall, 5'b00000);
    tick();
    ex_div_op = 1'b0;
    #1;
    check("div_idle_start", div_start, 1'b0);

    // Next divide while div_ready still shows the previous result
    ex_div_op = 1'b1;
    #1;
    tick();
    check("div2_start", div_start, 1'b1);
    check("div2_stale_ready_stall", stall, 5'b00111);
    tick();
    div_ready = 1'b0;
    #1;
    check("div2_busy_stall", stall, 5'b00111);
    check("div2_start_low", div_start, 1'b0);

    // Exception while BUSY aborts the divide
    mem_excepttype = 32'h4;
    #1;
    check("exc_div_abort", div_abort, 1'b1);
    check("exc_flush", flush, 5'b11111);
    check("exc_stall", stall, 5'b00000);
    check("exc_redirect", redirect_valid, 1'b1);
    check("exc_newpc", mem_newpc, 32'hBFC00380);
    tick();
    mem_excepttype = 32'd0; ex_div_op = 1'b0;
    #1;
    check("exc_abort_low", div_abort, 1'b0);
    check("exc_after_stall", stall, 5'b00000);
    // FSM back in IDLE: a new divide launches immediately
    ex_div_op = 1'b1;
    #1;
    tick();
    check("div3_start", div_start, 1'b1);
    tick();
    div_ready = 1'b1;
    #1;
    check("div3_ready_release", stall, 5'b00000);
    tick();
    ex_div_op = 1'b0;
    #1;
    check("div3_idle_stall", stall, 5'b00000);
    check("div3_idle_start", div_start, 1'b0);
    clear_inputs();

    // ERET
    mem_excepttype = 32'hE; mem_cp0_epc = 32'h80001234;
    #1;
    check("eret_redirect", redirect_valid, 1'b1);
    check("eret_newpc", mem_newpc, 32'h80001234);
    check("eret_flush", flush, 5'b11111);
    tick();
    mem_excepttype = 32'd0;
    #1;
    check("eret_after_redirect", redirect_valid, 1'b0);

    // Exception under fetch stall: redirect held 4 cycles
    mem_cp0_epc = 32'h12345678; mem_excepttype = 32'h8; stallreq_from_if = 1'b1;
    #1;
    check("pend_c1_redirect", redirect_valid, 1'b1);
    check("pend_c1_newpc", mem_newpc, 32'hBFC00380);
    tick();
    mem_excepttype = 32'd0;
    #1;
    check("pend_c2_redirect", redirect_valid, 1'b1);
    check("pend_c2_newpc", mem_newpc, 32'hBFC00380);
    check("pend_c2_flush", flush, 5'b00001);
    check("pend_c2_stall", stall, 5'b00011);
    tick();
    check("pend_c3_redirect", redirect_valid, 1'b1);
    check("pend_c3_newpc", mem_newpc, 32'hBFC00380);
    tick();
    stallreq_from_if = 1'b0;
    #1;
    check("pend_c4_redirect", redirect_valid, 1'b1);
    check("pend_c4_newpc", mem_newpc, 32'hBFC00380);
    check("pend_c4_flush", flush, 5'b00001);
    tick();
    check("pend_c5_redirect", redirect_valid, 1'b0);
    check("pend_c5_flush", flush, 5'b00000);

    // Reset while a redirect is pending clears it at once
    mem_excepttype = 32'h8; stallreq_from_if = 1'b1;
    #1;
    tick();
    mem_excepttype = 32'd0;
    #1;
    check("pre_rst_pending", redirect_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_redirect", redirect_valid, 1'b0);
    check("mid_rst_newpc", mem_newpc, 32'd0);
    check("mid_rst_cnt", stall_cycles, 4'd0);
    tick();
    rst = 1'b0;

    // Counter saturation under a long fetch stall
    repeat (14) tick();
    check("cnt_14", stall_cycles, 4'hE);
    repeat (6) tick();
    check("cnt_saturated", stall_cycles, 4'hF);
    check("pending_gone_after_rst", redirect_valid, 1'b0);
    clear_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
